sd_wr_status_rx: RTL

- Receives the SD write CRC-status token on DAT0 after each written block, then waits for the card to release DAT0 busy.
- Sits directly upstream of the data timeout counter. It drives that counter's running input and consumes its timeout flag.
- Reports token status and errors, plus a one-cycle done pulse, to the data write controller. The controller gates the next block and the interrupt logic on that pulse.

---
 rtl/sd_wr_status_rx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sd_wr_status_rx.sv
// SD write CRC-status receiver.
// Captures the CRC-status token that the card returns on DAT0 after each
// written block. It then waits for the card to release DAT0 busy while the
// downstream data timeout counter runs, and reports the result with a
// one-cycle done pulse.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | no write-status phase in progress
// GUARD      | ignoring DAT0 during the host end-bit turnaround
// WAIT_START | looking for the token start bit (DAT0 low)
// STATUS     | shifting in the three status bits, MSB first
// END_BIT    | checking the token end bit
// BUSY       | card holding DAT0 low; timeout counter running
// DONE       | one-cycle completion pulse
module sd_wr_status_rx #(
  parameter int MaxNcrc    = 8,
  parameter int StartGuard = 2,
  parameter int BusyGuard  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       sample_i,
  input  logic       dat0_i,
  input  logic       timeout_i,
  output logic       running_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] status_o,
  output logic       crc_err_o,
  output logic       write_err_o,
  output logic       token_err_o,
  output logic       timeout_err_o
);

  // The same counter also counts the three status bits, so it must reach at least 3.
  localparam int MaxA   = (MaxNcrc > StartGuard) ? MaxNcrc : StartGuard;
  localparam int MaxB   = (MaxA > BusyGuard) ? MaxA : BusyGuard;
  localparam int MaxCnt = (MaxB > 3) ? MaxB : 3;
  localparam int CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] GuardLast = CntW'(StartGuard - 1);
  localparam logic [CntW-1:0] NcrcLast  = CntW'(MaxNcrc - 1);
  localparam logic [CntW-1:0] BusyLen   = CntW'(BusyGuard);
  localparam logic [CntW-1:0] BitLast   = CntW'(2);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GUARD      = 3'd1,
    WAIT_START = 3'd2,
    STATUS     = 3'd3,
    END_BIT    = 3'd4,
    BUSY       = 3'd5,
    DONE       = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]      status_q, status_d;
  logic            crc_err_q, crc_err_d;
  logic            write_err_q, write_err_d;
  logic            token_err_q, token_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic            busy_guard_done;

  // Saturating increment and the busy-guard expiry, shared by all states.
  always_comb begin
    cnt_inc         = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
    busy_guard_done = !(cnt_q < BusyLen);
  end

  // State, counter, status and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      status_q      <= '0;
      crc_err_q     <= 1'b0;
      write_err_q   <= 1'b0;
      token_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      status_q      <= status_d;
      crc_err_q     <= crc_err_d;
      write_err_q   <= write_err_d;
      token_err_q   <= token_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic. Abort overrides everything and leaves the flags untouched.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    status_d      = status_q;
    crc_err_d     = crc_err_q;
    write_err_d   = write_err_q;
    token_err_d   = token_err_q;
    timeout_err_d = timeout_err_q;

    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d       = (StartGuard == 0) ? WAIT_START : GUARD;
            cnt_d         = '0;
            status_d      = '0;
            crc_err_d     = 1'b0;
            write_err_d   = 1'b0;
            token_err_d   = 1'b0;
            timeout_err_d = 1'b0;
          end
        end

        GUARD: begin
          if (sample_i) begin
            if (cnt_q == GuardLast) begin
              state_d = WAIT_START;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        WAIT_START: begin
          if (sample_i) begin
            if (!dat0_i) begin
              state_d = STATUS;
              cnt_d   = '0;
            end else if (cnt_q == NcrcLast) begin
              state_d     = DONE;
              cnt_d       = '0;
              token_err_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        STATUS: begin
          if (sample_i) begin
            status_d = {status_q[1:0], dat0_i};
            if (cnt_q == BitLast) begin
              state_d = END_BIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        END_BIT: begin
          if (sample_i) begin
            cnt_d = '0;
            if (dat0_i) begin
              // BUSY is entered whatever the code; the card still drives busy.
              state_d = BUSY;
              case (status_q)
                3'b010:  ;
                3'b101:  crc_err_d   = 1'b1;
                3'b110:  write_err_d = 1'b1;
                default: token_err_d = 1'b1;
              endcase
            end else begin
              state_d     = DONE;
              token_err_d = 1'b1;
            end
          end
        end

        BUSY: begin
          // A genuine release on the same cycle as a timeout is not an error.
          if (sample_i && dat0_i && busy_guard_done) begin
            state_d = DONE;
            cnt_d   = '0;
          end else if (timeout_i) begin
            state_d       = DONE;
            cnt_d         = '0;
            timeout_err_d = 1'b1;
          end else if (sample_i && !busy_guard_done) begin
            cnt_d = cnt_inc;
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded straight from registers, so they are clean after reset.
  always_comb begin
    busy_o        = (state_q != IDLE);
    running_o     = (state_q == BUSY);
    done_o        = (state_q == DONE);
    status_o      = status_q;
    crc_err_o     = crc_err_q;
    write_err_o   = write_err_q;
    token_err_o   = token_err_q;
    timeout_err_o = timeout_err_q;
  end

endmodule
